// File: rtl/coin_pkg.sv
// Coin-change dispenser shared definitions: coin indices, coin values, FSM encoding.
package coin_pkg;

  localparam int unsigned NUM_COINS  = 4;
  localparam int unsigned COIN_IDX_W = 2;
  localparam int unsigned COIN_VAL_W = 7;
  localparam int unsigned STATE_W    = 2;

  localparam logic [COIN_IDX_W-1:0] NICKEL  = 2'd0;
  localparam logic [COIN_IDX_W-1:0] DIME    = 2'd1;
  localparam logic [COIN_IDX_W-1:0] QUARTER = 2'd2;
  localparam logic [COIN_IDX_W-1:0] DOLLAR  = 2'd3;

  // Coin values in cents, indexed by coin index {dollar,quarter,dime,nickel}.
  localparam logic [NUM_COINS-1:0][COIN_VAL_W-1:0] COIN_VALUE = {7'd100, 7'd25, 7'd10, 7'd5};

  localparam logic [STATE_W-1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SELECT_ENC = 2'd1;
  localparam logic [STATE_W-1:0] ST_FIRE_ENC   = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE_ENC   = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SELECT = ST_SELECT_ENC,
    ST_FIRE   = ST_FIRE_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_t;

  // Value in cents of the coin at the given index.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [COIN_IDX_W-1:0] idx);
    return COIN_VALUE[idx];
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin whose value fits the remaining amount and is in stock.
module coin_select
  import coin_pkg::*;
#(
  parameter int unsigned AMT_W = 10,
  parameter int unsigned INV_W = 8
) (
  input  logic [AMT_W-1:0]                remaining,
  input  logic [NUM_COINS-1:0][INV_W-1:0] inv,
  output logic                            found_c,
  output logic [COIN_IDX_W-1:0]           idx_c
);

  // Ascending scan; the last eligible coin wins, which is the largest one.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      if ((AMT_W'(coin_value(COIN_IDX_W'(i))) <= remaining) && (inv[i] != '0)) begin
        found_c = 1'b1;
        idx_c   = COIN_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays out change greedily, one coin at a time, over a fire/ack hopper handshake.
module coin_change_dispenser
  import coin_pkg::*;
#(
  parameter int unsigned AMT_W   = 10,
  parameter int unsigned INV_W   = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chg_valid,
  input  logic [AMT_W-1:0]       chg_amt,
  output logic                   chg_ready,
  input  logic                   refill_en,
  input  logic [1:0]             refill_sel,
  input  logic [INV_W-1:0]       refill_cnt,
  output logic [NUM_COINS-1:0]   coin_fire,
  input  logic                   hopper_ack,
  output logic                   done,
  output logic                   short,
  output logic [AMT_W-1:0]       short_amt,
  output logic                   jam,
  output logic [4*INV_W-1:0]     inventory
);

  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t                          state, state_nxt;
  logic [AMT_W-1:0]                remaining, rem_nxt;
  logic [NUM_COINS-1:0][INV_W-1:0] inv, inv_nxt;
  logic [COIN_IDX_W-1:0]           sel_idx, idx_nxt;
  logic [TMO_W-1:0]                tmo_cnt, tmo_nxt;
  logic                            short_nxt, jam_nxt;
  logic [AMT_W-1:0]                short_amt_nxt;
  logic                            ready_nxt, done_nxt;
  logic [NUM_COINS-1:0]            fire_nxt;
  logic                            pick_found_c;
  logic [COIN_IDX_W-1:0]           pick_idx_c;

  // Saturating inventory add.
  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                               input logic [INV_W-1:0] b);
    logic [INV_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
  endfunction

  coin_select #(
    .AMT_W (AMT_W),
    .INV_W (INV_W)
  ) u_select (
    .remaining (remaining),
    .inv       (inv),
    .found_c   (pick_found_c),
    .idx_c     (pick_idx_c)
  );

  assign inventory = inv;

  // Next-state, datapath updates and next registered outputs.
  always_comb begin
    state_nxt     = state;
    rem_nxt       = remaining;
    inv_nxt       = inv;
    idx_nxt       = sel_idx;
    tmo_nxt       = tmo_cnt;
    short_nxt     = short;
    short_amt_nxt = short_amt;
    jam_nxt       = jam;

    case (state)
      ST_IDLE: begin
        if (refill_en) begin
          inv_nxt[refill_sel] = sat_add(inv[refill_sel], refill_cnt);
        end
        if (chg_valid) begin
          rem_nxt       = chg_amt;
          short_nxt     = 1'b0;
          short_amt_nxt = '0;
          state_nxt     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        tmo_nxt = '0;
        if (remaining == '0) begin
          short_nxt = 1'b0;
          state_nxt = ST_DONE;
        end else if (jam || !pick_found_c) begin
          // A jammed hopper is never fired again; the whole remainder is owed.
          short_nxt     = 1'b1;
          short_amt_nxt = remaining;
          state_nxt     = ST_DONE;
        end else begin
          idx_nxt   = pick_idx_c;
          state_nxt = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (hopper_ack) begin
          rem_nxt          = remaining - AMT_W'(coin_value(sel_idx));
          inv_nxt[sel_idx] = inv[sel_idx] - INV_W'(1);
          tmo_nxt          = '0;
          state_nxt        = ST_SELECT;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          // Coin in flight is not deducted: we cannot know whether it left.
          jam_nxt       = 1'b1;
          short_nxt     = 1'b1;
          short_amt_nxt = remaining;
          state_nxt     = ST_DONE;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    ready_nxt = (state_nxt == ST_IDLE);
    done_nxt  = (state_nxt == ST_DONE);
    fire_nxt  = (state_nxt == ST_FIRE) ? (4'b0001 << idx_nxt) : '0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      inv       <= '0;
      sel_idx   <= '0;
      tmo_cnt   <= '0;
      short     <= 1'b0;
      short_amt <= '0;
      jam       <= 1'b0;
      chg_ready <= 1'b1;
      done      <= 1'b0;
      coin_fire <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      inv       <= inv_nxt;
      sel_idx   <= idx_nxt;
      tmo_cnt   <= tmo_nxt;
      short     <= short_nxt;
      short_amt <= short_amt_nxt;
      jam       <= jam_nxt;
      chg_ready <= ready_nxt;
      done      <= done_nxt;
      coin_fire <= fire_nxt;
    end
  end

endmodule
